// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared funct3 codes, FSM state type and access-legality helpers
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == SB) || (f3 == SH) || (f3 == SW);
        return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    endfunction

    // Low two funct3 bits encode size for every legal code: 01 half, 10 word
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_formatter.sv
// ============================================================================
// Module   : load_formatter
// Purpose  : Selects the addressed byte/half of a bus word and extends it
// Revision : 1.0
// ============================================================================
`default_nettype none

module load_formatter
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] w_shifted;

    always_comb begin
        w_shifted = rdata >> {addr_lo, 3'b000};
        case (funct3)
            LB:      data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            LH:      data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            LBU:     data = {24'd0, w_shifted[7:0]};
            LHU:     data = {16'd0, w_shifted[15:0]};
            default: data = w_shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage load/store unit driving a ready-handshake bus with timeout
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  funct3M,
    input  logic        MemWriteM,
    input  logic        MemReadM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic [1:0]  r_addr_lo;
    logic [2:0]  r_funct3;
    logic        r_err;

    logic        w_access;
    logic        w_we;
    logic        w_legal;
    logic        w_start;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_load;

    assign w_access  = MemReadM | MemWriteM;
    assign w_we      = MemWriteM;
    assign w_legal   = is_legal(w_we, funct3M) && !is_misaligned(funct3M, ALUResultM[1:0]);
    assign w_start   = (r_state == IDLE) && w_access && w_legal;
    // bus_ready on the final allowed cycle still completes the access
    assign w_timeout = (r_state == REQ) && !bus_ready && ((r_cnt + 8'd1) == c_TIMEOUT);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
        if (w_we) begin
            case (funct3M)
                SB: begin
                    w_be    = 4'b0001 << ALUResultM[1:0];
                    w_wdata = {4{WriteDataM[7:0]}};
                end
                SH: begin
                    w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{WriteDataM[15:0]}};
                end
                default: ;
            endcase
        end
    end

    load_formatter u_load_formatter (
        .rdata   (bus_rdata),
        .addr_lo (r_addr_lo),
        .funct3  (r_funct3),
        .data    (w_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = REQ;
            REQ:     if (bus_ready || w_timeout) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        StallM    = w_start || (r_state == REQ);
        MisalignM = (r_state == IDLE) && w_access && !w_legal;
        BusErrM   = (r_state == DONE) && r_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 32'd0;
            bus_wdata <= 32'd0;
            bus_be    <= 4'd0;
            ReadDataM <= 32'd0;
            r_cnt     <= 8'd0;
            r_addr_lo <= 2'd0;
            r_funct3  <= 3'd0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        bus_req   <= 1'b1;
                        bus_we    <= w_we;
                        bus_addr  <= {ALUResultM[31:2], 2'b00};
                        bus_be    <= w_be;
                        bus_wdata <= w_wdata;
                        r_addr_lo <= ALUResultM[1:0];
                        r_funct3  <= funct3M;
                        r_cnt     <= 8'd0;
                        r_err     <= 1'b0;
                    end
                end
                REQ: begin
                    if (bus_ready) begin
                        bus_req <= 1'b0;
                        if (!bus_we)
                            ReadDataM <= w_load;
                    end else if (w_timeout) begin
                        bus_req   <= 1'b0;
                        ReadDataM <= 32'd0;
                        r_err     <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                DONE:    r_err <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Scoreboard bench for mem_access_unit with a randomized bus slave
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ALUResultM = '0;
    logic [31:0] WriteDataM = '0;
    logic [2:0]  funct3M = '0;
    logic        MemWriteM = 1'b0;
    logic        MemReadM = 1'b0;
    logic [31:0] ReadDataM;
    logic        StallM, MisalignM, BusErrM;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_rdata = '0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .funct3M(funct3M),
        .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    // kind: 0 = misalign flag, 1 = bus request issued, 2 = access completion
    typedef struct {
        int          kind;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          stalls;
        logic        err;
        logic [31:0] rd;
    } exp_t;

    typedef struct {
        int          lat;
        logic [31:0] rdata;
    } rsp_t;

    exp_t        sb_q[$];
    rsp_t        rsp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic pop_exp(input int kind, output exp_t e, output bit ok);
        ok = 1'b0;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_underflow: DUT event kind %0d, none expected at %0t", kind, $time);
        end else begin
            e = sb_q.pop_front();
            if (e.kind != kind) begin
                errors++;
                $display("FAIL event_kind: got %0d expected %0d at %0t", kind, e.kind, $time);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    // Access rules restated as size/alignment arithmetic
    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit model_ok(input bit we, input logic [2:0] f3, input logic [31:0] addr);
        int sz;
        sz = acc_size(f3);
        if (sz == 0 || (we && f3 > 3'd2))
            return 1'b0;
        return (addr % sz) == 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * lo);
        case (f3)
            3'd0:    return 32'($signed(v[7:0]));
            3'd1:    return 32'($signed(v[15:0]));
            3'd4:    return 32'(v[7:0]);
            3'd5:    return 32'(v[15:0]);
            default: return rd;
        endcase
    endfunction

    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int lat, input logic [31:0] rdata);
        exp_t e;
        int   sz;
        int   nreq;
        int   guard;
        @(negedge clk);
        MemReadM   = rd;
        MemWriteM  = wr;
        funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
        if (!rd && !wr) begin
            #1;
            chk("idle_stall", 32'(StallM), 32'd0);
            return;
        end
        e = '{kind: 0, we: wr, addr: '0, wdata: '0, be: '0, stalls: 0, err: 1'b0, rd: '0};
        if (!model_ok(wr, f3, addr)) begin
            sb_q.push_back(e);
        end else begin
            sz = acc_size(f3);
            rsp_q.push_back('{lat: lat, rdata: rdata});
            e.kind  = 1;
            e.addr  = addr & 32'hFFFF_FFFC;
            e.be    = wr ? 4'(((1 << sz) - 1) << (addr % 4)) : 4'hF;
            e.wdata = (sz == 1) ? {4{wd[7:0]}} : (sz == 2) ? {2{wd[15:0]}} : wd;
            sb_q.push_back(e);
            nreq = (lat < TO) ? lat + 1 : TO;
            if (lat >= TO)
                model_rd = '0;
            else if (!wr)
                model_rd = model_load(f3, addr[1:0], rdata);
            e.kind   = 2;
            e.stalls = 1 + nreq;
            e.err    = (lat >= TO);
            e.rd     = model_rd;
            sb_q.push_back(e);
        end
        #1;
        guard = 0;
        while (StallM && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 50)
            chk("stall_release", 32'd1, 32'd0);
    endtask

    // Bus slave: answers after the latency queued by the driver, junk ready otherwise
    initial begin : responder
        bit   active;
        int   cnt;
        rsp_t cur;
        active = 1'b0;
        cnt    = 0;
        cur    = '{lat: 1000, rdata: '0};
        forever begin
            @(negedge clk);
            if (rst) begin
                active    = 1'b0;
                bus_ready = 1'b0;
                continue;
            end
            if (bus_req && !active) begin
                active = 1'b1;
                cnt    = 0;
                if (rsp_q.size() > 0)
                    cur = rsp_q.pop_front();
                else
                    cur = '{lat: 1000, rdata: '0};
            end else if (!bus_req) begin
                active = 1'b0;
            end
            if (active) begin
                bus_ready = (cnt == cur.lat);
                bus_rdata = bus_ready ? cur.rdata : $urandom;
                cnt++;
            end else begin
                bus_ready = 1'($urandom_range(0, 1));
                bus_rdata = $urandom;
            end
        end
    end

    initial begin : monitor
        logic prev_req;
        int   stalls;
        exp_t e;
        exp_t hold;
        bit   ok;
        prev_req = 1'b0;
        stalls   = 0;
        hold     = '{kind: 1, we: 1'b0, addr: '0, wdata: '0, be: '0, stalls: 0, err: 1'b0, rd: '0};
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_req = 1'b0;
                stalls   = 0;
                continue;
            end
            if (StallM)
                stalls++;
            if (MisalignM) begin
                pop_exp(0, e, ok);
                if (ok) chk("misalign_stall", 32'(StallM), 32'd0);
                stalls = 0;
            end
            if (bus_req && !prev_req) begin
                pop_exp(1, e, ok);
                if (ok) begin
                    chk("bus_we", 32'(bus_we), 32'(e.we));
                    chk("bus_addr", bus_addr, e.addr);
                    chk("bus_be", 32'(bus_be), 32'(e.be));
                    if (e.we) chk("bus_wdata", bus_wdata, e.wdata);
                    hold = e;
                end
            end else if (bus_req) begin
                chk("bus_hold_addr", bus_addr, hold.addr);
                chk("bus_hold_we_be", {27'd0, bus_we, bus_be}, {27'd0, hold.we, hold.be});
            end
            if (!bus_req && prev_req) begin
                pop_exp(2, e, ok);
                if (ok) begin
                    chk("stall_cycles", 32'(stalls), 32'(e.stalls));
                    chk("done_stall", 32'(StallM), 32'd0);
                    chk("bus_err", 32'(BusErrM), 32'(e.err));
                    chk("read_data", ReadDataM, e.rd);
                end
                stalls = 0;
            end else if (BusErrM) begin
                chk("buserr_outside_done", 32'(BusErrM), 32'd0);
            end
            prev_req = bus_req;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int          op;
        logic [2:0]  f3;
        logic [2:0]  legal_codes[5];
        legal_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        @(negedge clk);
        #1;
        chk("rst_ReadDataM", ReadDataM, 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'd0);
        chk("rst_StallM", 32'(StallM), 32'd0);
        chk("rst_MisalignM", 32'(MisalignM), 32'd0);
        chk("rst_BusErrM", 32'(BusErrM), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        access(1, 0, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        access(1, 0, 3'd0, 32'h103, 32'h0, 0, 32'h80000000);
        access(1, 0, 3'd4, 32'h103, 32'h0, 0, 32'h80000000);
        access(0, 1, 3'd1, 32'h102, 32'h1234ABCD, 1, 32'h0);
        access(1, 0, 3'd2, 32'h101, 32'h0, 0, 32'h0);
        access(1, 0, 3'd2, 32'h200, 32'h0, 10, 32'h0);
        access(1, 1, 3'd0, 32'h301, 32'hA5A5A5A5, 2, 32'h0);
        access(1, 0, 3'd1, 32'h402, 32'h0, 3, 32'h8001_7FFF);
        access(0, 1, 3'd4, 32'h400, 32'h0, 0, 32'h0);

        for (int i = 0; i < 150; i++) begin
            op = $urandom_range(0, 9);
            if ($urandom_range(0, 9) < 7)
                f3 = legal_codes[$urandom_range(0, 4)];
            else
                f3 = 3'($urandom_range(0, 7));
            access(op >= 1 && op <= 5 || op == 9, op >= 6, f3, $urandom, $urandom,
                   $urandom_range(0, 5), $urandom);
        end

        // Reset during the second REQ cycle of a pending read
        @(negedge clk);
        MemReadM   = 1'b1;
        MemWriteM  = 1'b0;
        funct3M    = 3'd2;
        ALUResultM = 32'h300;
        rsp_q.push_back('{lat: 10, rdata: '0});
        sb_q.push_back('{kind: 1, we: 1'b0, addr: 32'h300, wdata: '0, be: 4'hF,
                         stalls: 0, err: 1'b0, rd: '0});
        @(negedge clk);
        @(negedge clk);
        #3;
        rst      = 1'b1;
        MemReadM = 1'b0;
        #1;
        chk("midrst_bus_req", 32'(bus_req), 32'd0);
        chk("midrst_BusErrM", 32'(BusErrM), 32'd0);
        chk("midrst_StallM", 32'(StallM), 32'd0);
        chk("midrst_ReadDataM", ReadDataM, 32'd0);
        chk("midrst_bus_addr", bus_addr, 32'd0);
        @(negedge clk);
        #3;
        rst      = 1'b0;
        model_rd = '0;

        access(1, 0, 3'd5, 32'h502, 32'h0, 1, 32'hBEEF_0000);
        access(0, 0, 3'd0, 32'h0, 32'h0, 0, 32'h0);
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
        repeat (5) @(negedge clk);
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
